// File: rtl/demux_route_feeder.sv
// -----------------------------------------------------------------------------
// demux_route_feeder
//
// Upstream feeder for a 1-to-3 byte demux (outputs A/B/C). Requests of the
// form {destination, byte} are accepted over a valid/ready handshake and
// buffered in a small FIFO. The output stage presents one destination per
// cycle on registered out/sel lines. Destination 0 broadcasts the byte to
// A, B and C on three consecutive cycles.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-high reset
//   in_data   in   byte to route
//   in_dest   in   0=broadcast, 1=A, 2=B, 3=C
//   in_valid  in   request present
//   in_ready  out  FIFO can accept (derived from registered count only)
//   hold      in   downstream stall; freezes the output stage
//   out       out  data to demux
//   sel       out  demux select: A=001, B=010, C=011, idle=000
//   out_valid out  out/sel carry a live routing
//   count     out  FIFO occupancy
//   busy      out  output stage active or FIFO non-empty
// -----------------------------------------------------------------------------
module demux_route_feeder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4   // power of 2, minimum 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [1:0]               in_dest,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     hold,
  output logic [WIDTH-1:0]         out,
  output logic [2:0]               sel,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ONE,
    S_BC_A,
    S_BC_B,
    S_BC_C
  } state_t;

  localparam logic [2:0] SEL_IDLE = 3'b000;
  localparam logic [2:0] SEL_A    = 3'b001;
  localparam logic [2:0] SEL_B    = 3'b010;
  localparam logic [2:0] SEL_C    = 3'b011;

  state_t            state;
  logic [WIDTH+1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;
  logic              load;
  logic              can_load;
  logic [1:0]        head_dest;
  logic [WIDTH-1:0]  head_data;

  // Ready depends on the registered count only, so a pop in the same cycle
  // never opens a slot early.
  assign in_ready  = (count != CW'(DEPTH));
  assign push      = in_valid && in_ready;

  // A new entry may be loaded when the stage is idle or finishing its last
  // beat (single routing or third broadcast beat).
  assign can_load  = (state == S_IDLE) || (state == S_ONE) || (state == S_BC_C);
  assign load      = !hold && (count != '0) && can_load;

  assign head_dest = mem[rd_ptr][WIDTH+1:WIDTH];
  assign head_data = mem[rd_ptr][WIDTH-1:0];

  assign busy      = (state != S_IDLE) || (count != '0);

  // NOTE: the storage array has no reset; stale entries are unreachable once
  // the pointers and count are cleared, and leaving it unreset keeps it a
  // plain register file / RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_dest, in_data};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Output stage: state and all outputs registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      out       <= '0;
      sel       <= SEL_IDLE;
      out_valid <= 1'b0;
    end else if (!hold) begin
      unique case (state)
        S_IDLE, S_ONE, S_BC_C: begin
          if (load) begin
            out       <= head_data;
            out_valid <= 1'b1;
            if (head_dest == 2'd0) begin
              state <= S_BC_A;
              sel   <= SEL_A;
            end else begin
              state <= S_ONE;
              sel   <= {1'b0, head_dest};
            end
          end else begin
            state     <= S_IDLE;
            out       <= '0;
            sel       <= SEL_IDLE;
            out_valid <= 1'b0;
          end
        end
        // Broadcast beats keep out unchanged and only step sel.
        S_BC_A: begin
          state <= S_BC_B;
          sel   <= SEL_B;
        end
        S_BC_B: begin
          state <= S_BC_C;
          sel   <= SEL_C;
        end
        default: begin
          state     <= S_IDLE;
          out       <= '0;
          sel       <= SEL_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_route_feeder.sv
// -----------------------------------------------------------------------------
// tb_demux_route_feeder
//
// Self-checking bench for demux_route_feeder. A reference model keeps the
// FIFO as a queue of requests and the output stage as a queue of remaining
// select beats for the entry on display. A compare process checks every DUT
// output against the model on each falling edge; directed scenarios add
// literal expectations, followed by a randomized traffic phase.
// -----------------------------------------------------------------------------
module tb_demux_route_feeder;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_dest;
  logic             in_valid;
  logic             in_ready;
  logic             hold;
  logic [WIDTH-1:0] out;
  logic [2:0]       sel;
  logic             out_valid;
  logic [CW-1:0]    count;
  logic             busy;

  demux_route_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .hold      (hold),
    .out       (out),
    .sel       (sel),
    .out_valid (out_valid),
    .count     (count),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0]       dest;
    logic [WIDTH-1:0] data;
  } req_t;

  req_t             mq[$];     // buffered requests
  int               beats[$];  // sel codes still to show for current entry
  logic [WIDTH-1:0] cur_data;
  req_t             m_req;
  req_t             m_pop;
  bit               m_push;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      beats.delete();
      cur_data = '0;
    end else begin
      m_push = in_valid && (mq.size() < DEPTH);
      if (!hold) begin
        if (beats.size() > 1) begin
          void'(beats.pop_front());
        end else begin
          beats.delete();
          if (mq.size() > 0) begin
            m_pop    = mq.pop_front();
            cur_data = m_pop.data;
            if (m_pop.dest == 2'd0) beats = '{1, 2, 3};
            else                    beats = '{int'(m_pop.dest)};
          end
        end
      end
      if (m_push) begin
        m_req.dest = in_dest;
        m_req.data = in_data;
        mq.push_back(m_req);
      end
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("out",       32'(out),       (beats.size() > 0) ? 32'(cur_data) : 32'd0);
      check("sel",       32'(sel),       (beats.size() > 0) ? 32'(beats[0]) : 32'd0);
      check("out_valid", 32'(out_valid), 32'(beats.size() > 0));
      check("count",     32'(count),     32'(mq.size()));
      check("in_ready",  32'(in_ready),  32'(mq.size() < DEPTH));
      check("busy",      32'(busy),      32'((beats.size() > 0) || (mq.size() > 0)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [1:0] d, input logic [WIDTH-1:0] x);
    in_valid = v;
    in_dest  = d;
    in_data  = x;
  endtask

  initial begin
    rst = 1'b1;
    hold = 1'b0;
    drive(1'b0, 2'd0, 8'h00);
    #1;
    check("rst_out",   32'(out),       32'd0);
    check("rst_sel",   32'(sel),       32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count),     32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(in_ready), 32'd1);
    cmp_en = 1'b1;

    // Single routing: push at edge 1, visible after edge 2, idle after edge 3.
    drive(1'b1, 2'd1, 8'h5A);
    step();
    drive(1'b0, 2'd0, 8'h00);
    check("single_pre_valid", 32'(out_valid), 32'd0);
    step();
    check("single_out", 32'(out), 32'h5A);
    check("single_sel", 32'(sel), 32'd1);
    check("single_vld", 32'(out_valid), 32'd1);
    step();
    check("single_idle_sel", 32'(sel), 32'd0);
    check("single_idle_vld", 32'(out_valid), 32'd0);
    check("single_idle_out", 32'(out), 32'd0);

    // Broadcast: three beats A, B, C carrying the same byte.
    drive(1'b1, 2'd0, 8'hC3);
    step();
    drive(1'b0, 2'd0, 8'h00);
    for (int i = 1; i <= 3; i++) begin
      step();
      check("bc_sel", 32'(sel), 32'(i));
      check("bc_out", 32'(out), 32'hC3);
      check("bc_vld", 32'(out_valid), 32'd1);
    end
    step();
    check("bc_idle_vld", 32'(out_valid), 32'd0);

    // Back-to-back traffic with no bubbles.
    drive(1'b1, 2'd2, 8'h11);
    step();
    drive(1'b1, 2'd3, 8'h22);
    step();
    check("b2b_sel0", 32'(sel), 32'd2);
    check("b2b_out0", 32'(out), 32'h11);
    drive(1'b1, 2'd1, 8'h33);
    step();
    drive(1'b0, 2'd0, 8'h00);
    check("b2b_sel1", 32'(sel), 32'd3);
    check("b2b_out1", 32'(out), 32'h22);
    step();
    check("b2b_sel2", 32'(sel), 32'd1);
    check("b2b_out2", 32'(out), 32'h33);
    check("b2b_vld2", 32'(out_valid), 32'd1);
    step();
    check("b2b_idle", 32'(out_valid), 32'd0);

    // Full FIFO under hold: fifth request is refused.
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'((i % 3) + 1), 8'(8'hA0 + i));
      step();
    end
    drive(1'b0, 2'd0, 8'h00);
    check("full_count", 32'(count), 32'd4);
    check("full_ready", 32'(in_ready), 32'd0);
    check("full_idle",  32'(out_valid), 32'd0);
    hold = 1'b0;
    step();
    check("full_pop_out",   32'(out), 32'hA0);
    check("full_pop_ready", 32'(in_ready), 32'd1);
    check("full_pop_count", 32'(count), 32'd3);
    for (int i = 1; i < 4; i++) begin
      step();
      check("full_drain_out", 32'(out), 32'(8'hA0 + i));
      check("full_drain_sel", 32'(sel), 32'((i % 3) + 1));
    end
    step();
    check("full_done_vld", 32'(out_valid), 32'd0);

    // Hold in the middle of a broadcast.
    drive(1'b1, 2'd0, 8'h77);
    step();
    drive(1'b0, 2'd0, 8'h00);
    step();
    step();
    check("hbc_sel_b", 32'(sel), 32'd2);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hbc_hold_sel", 32'(sel), 32'd2);
      check("hbc_hold_out", 32'(out), 32'h77);
    end
    hold = 1'b0;
    step();
    check("hbc_resume_sel", 32'(sel), 32'd3);
    check("hbc_resume_out", 32'(out), 32'h77);
    step();

    // Async reset during BC_B with two entries queued.
    drive(1'b1, 2'd0, 8'h99);
    step();
    drive(1'b1, 2'd1, 8'h01);
    step();
    drive(1'b1, 2'd2, 8'h02);
    step();
    drive(1'b0, 2'd0, 8'h00);
    check("ar_pre_sel",   32'(sel), 32'd2);
    check("ar_pre_count", 32'(count), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("ar_out",   32'(out), 32'd0);
    check("ar_sel",   32'(sel), 32'd0);
    check("ar_vld",   32'(out_valid), 32'd0);
    check("ar_count", 32'(count), 32'd0);
    check("ar_busy",  32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("ar_after_vld", 32'(out_valid), 32'd0);
    end

    // Randomized traffic with occasional stalls.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), 8'($urandom));
      hold = ($urandom_range(0, 3) == 0);
      step();
    end
    drive(1'b0, 2'd0, 8'h00);
    hold = 1'b0;
    repeat (20) step();
    check("final_count", 32'(count), 32'd0);
    check("final_busy",  32'(busy), 32'd0);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
